// File: rtl/btb_predictor.sv
// Tagged branch target buffer with per-entry saturating direction counters.
// Table valid bits are cleared by a one-entry-per-cycle sweep after reset or inv_all.
module btb_predictor #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 10,
  parameter int TAG_W = 5,
  parameter int CTR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic [PC_W-1:0] predicted,
  output logic            pred_hit,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            inv_all,
  output logic            busy
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_ONE << (CTR_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  logic [CTR_W-1:0] ctr_q    [DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, upd_en;

  assign busy   = (state_q == CLEAR);
  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[IDX_W+TAG_W:IDX_W+1];
  assign up_idx = upd_pc[IDX_W:1];
  assign up_tag = upd_pc[IDX_W+TAG_W:IDX_W+1];

  assign pred_hit  = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predicted = (pred_hit && ctr_q[lk_idx][CTR_W-1]) ? target_q[lk_idx]
                                                          : lookup_pc + PC_W'(2);

  // An invalidate request in the same cycle wins over the update.
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign upd_en = !reset && (state_q == IDLE) && !inv_all && upd_valid;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (inv_all) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        if (inv_all) begin
          sweep_d = '0;
        end else if (sweep_q == IDX_LAST) begin
          state_d = IDLE;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        sweep_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (upd_en && !up_hit && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload fields are never cleared; the valid bit alone gates their use.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_ONE;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_ONE;
        end
      end else if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_INIT;
      end
    end
  end

endmodule
